// File: rtl/dmem_arb_pkg.sv
// Shared constants for the DataMemory two-port arbiter: FSM encoding,
// default widths and requester indices.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int REQ_DP  = 0;
    localparam int REQ_DBG = 1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker. On a tie the requester that was
// not granted last wins; grant is one-hot, or zero when nothing is requested.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (req == 2'b11)
            grant_idx = ~last_grant;
        else if (req[1])
            grant_idx = 1'b1;
        grant = 2'b00;
        if (|req)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port DataMemory between
// the datapath (r0) and the loader/debug port (r1). One access per 3 cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_req_we,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_resp_valid,
    output logic [DATA_W-1:0] r0_resp_rdata,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_req_we,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_resp_valid,
    output logic [DATA_W-1:0] r1_resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_memo_read,
    output logic              mem_memo_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    logic [1:0]        state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;
    logic              r0_vld_q;
    logic              r1_vld_q;

    logic [1:0]        grant;
    logic              grant_idx;
    logic              in_idle;
    logic              in_access;
    logic              accept;
    logic [DATA_W-1:0] rdata_d;

    rr_arb2 u_arb (
        .req        ({r1_req_valid, r0_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);

    assign r0_req_ready = in_idle && grant[REQ_DP]  && !reset;
    assign r1_req_ready = in_idle && grant[REQ_DBG] && !reset;
    assign accept       = r0_req_ready || r1_req_ready;

    // Strobes are gated with reset so an aborted write never commits.
    assign mem_memo_write = in_access &&  we_q && !reset;
    assign mem_memo_read  = in_access && !we_q && !reset;
    assign mem_address    = in_access ? addr_q  : '0;
    assign mem_data_write = in_access ? wdata_q : '0;

    assign rdata_d = we_q ? '0 : mem_data_read;

    assign r0_resp_valid = r0_vld_q;
    assign r1_resp_valid = r1_vld_q;
    assign r0_resp_rdata = r0_rdata_q;
    assign r1_resp_rdata = r1_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            r0_vld_q     <= 1'b0;
            r1_vld_q     <= 1'b0;
        end else begin
            r0_vld_q <= 1'b0;
            r1_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        we_q         <= grant_idx ? r1_req_we    : r0_req_we;
                        addr_q       <= grant_idx ? r1_req_addr  : r0_req_addr;
                        wdata_q      <= grant_idx ? r1_req_wdata : r0_req_wdata;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Response regs load alongside rdata_q so DONE shows it directly.
                    rdata_q <= rdata_d;
                    if (owner_q) begin
                        r1_rdata_q <= rdata_d;
                        r1_vld_q   <= 1'b1;
                    end else begin
                        r0_rdata_q <= rdata_d;
                        r0_vld_q   <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural DataMemory, response
// scoreboard fed at acceptance, and per-scenario directed checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic          r0_req_we = 1'b0, r1_req_we = 1'b0;
    logic [AW-1:0] r0_req_addr = '0, r1_req_addr = '0;
    logic [DW-1:0] r0_req_wdata = '0, r1_req_wdata = '0;
    logic          r0_req_ready, r1_req_ready;
    logic          r0_resp_valid, r1_resp_valid;
    logic [DW-1:0] r0_resp_rdata, r1_resp_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic          mem_memo_read, mem_memo_write;
    logic [DW-1:0] mem_data_read;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
        .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
        .r0_resp_valid(r0_resp_valid), .r0_resp_rdata(r0_resp_rdata),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
        .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
        .r1_resp_valid(r1_resp_valid), .r1_resp_rdata(r1_resp_rdata),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_memo_read(mem_memo_read), .mem_memo_write(mem_memo_write),
        .mem_data_read(mem_data_read)
    );

    always #5 clk = ~clk;

    // Behavioural DataMemory: combinational read, write on rising clk.
    logic [DW-1:0] mem [256] = '{default: '0};
    assign mem_data_read = mem[mem_address[7:0]];
    always @(posedge clk) if (mem_memo_write) mem[mem_address[7:0]] <= mem_data_write;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [DW-1:0] d; int c; } rsp_t;
    typedef struct { int c; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } stb_t;

    rsp_t obs_q[$];
    stb_t stb_q[$];
    always @(negedge clk) begin
        if (r0_resp_valid) obs_q.push_back('{id: 0, d: r0_resp_rdata, c: cyc});
        if (r1_resp_valid) obs_q.push_back('{id: 1, d: r1_resp_rdata, c: cyc});
        if (mem_memo_read || mem_memo_write)
            stb_q.push_back('{c: cyc, we: mem_memo_write, a: mem_address, d: mem_data_write});
    end

    rsp_t          exp_q[$];
    int            obs_rd = 0;
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int            nvec = 0;
    int            nerr = 0;

    task automatic tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic drv(input int id, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            r0_req_valid = v; r0_req_we = we; r0_req_addr = a; r0_req_wdata = d;
        end else begin
            r1_req_valid = v; r1_req_we = we; r1_req_addr = a; r1_req_wdata = d;
        end
    endtask

    // Raise a request and wait (bounded) until ready; returns at the acceptance cycle.
    task automatic issue(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit push, output int c, output bit ok);
        ok = 0;
        c  = 0;
        drv(id, 1'b1, we, a, d);
        #1;
        for (int k = 0; k < 12; k++) begin
            if ((id == 0) ? r0_req_ready : r1_req_ready) begin
                ok = 1;
                c  = cyc;
                break;
            end
            tick();
        end
        if (ok && push) begin
            exp_q.push_back('{id: id, d: (we ? '0 : ref_mem[a[7:0]]), c: c + 2});
            if (we) ref_mem[a[7:0]] = d;
        end
    endtask

    task automatic release_req(input int id);
        tick();
        drv(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic sb_drain(input string name);
        rsp_t o, e;
        repeat (4) tick();
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL %s unexpected_resp: got id=%0d data=%h cyc=%0d, want none", name, o.id, o.d, o.c);
            end else begin
                e = exp_q.pop_front();
                if (o.id !== e.id || o.d !== e.d || o.c !== e.c) begin
                    nerr++;
                    $display("FAIL %s resp: got id=%0d data=%h cyc=%0d, want id=%0d data=%h cyc=%0d",
                             name, o.id, o.d, o.c, e.id, e.d, e.c);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nvec++; nerr++;
            $display("FAIL %s missing_resp: got none, want id=%0d data=%h cyc=%0d", name, e.id, e.d, e.c);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] got [10];
        reset = 1'b1;
        drv(0, 1'b1, 1'b1, 16'h0003, 16'h1234);
        drv(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        tick(); tick();
        got = '{DW'(r0_req_ready), DW'(r1_req_ready), DW'(mem_memo_read), DW'(mem_memo_write),
                mem_address, mem_data_write, DW'(r0_resp_valid), DW'(r1_resp_valid),
                r0_resp_rdata, r1_resp_rdata};
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (got[i] !== '0) begin
                nerr++;
                $display("FAIL reset_out%0d: got %h want 0", i, got[i]);
            end
        end
        drv(0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int c0, c1; bit ok0, ok1;
        issue(0, 1'b1, 16'd5, 16'hABCD, 1, c0, ok0);
        release_req(0);
        issue(1, 1'b0, 16'd5, 16'h0000, 1, c1, ok1);
        release_req(1);
        nvec++;
        if (!ok0 || !ok1 || (c1 - c0) != 3) begin
            nerr++;
            $display("FAIL wr_rd_spacing: got ok=%0d%0d gap=%0d want ok=11 gap=3", ok0, ok1, c1 - c0);
        end
        sb_drain("wr_rd");
    endtask

    task automatic test_tie();
        int c0, c1; bit ok;
        reset = 1'b1; tick(); reset = 1'b0;
        drv(0, 1'b1, 1'b0, 16'd5, '0);
        drv(1, 1'b1, 1'b0, 16'd5, '0);
        #1;
        nvec++;
        if (r0_req_ready !== 1'b1 || r1_req_ready !== 1'b0) begin
            nerr++;
            $display("FAIL tie_ready: got r0=%b r1=%b want r0=1 r1=0", r0_req_ready, r1_req_ready);
        end
        c0 = cyc;
        exp_q.push_back('{id: 0, d: ref_mem[5], c: c0 + 2});
        release_req(0);
        issue(1, 1'b0, 16'd5, '0, 1, c1, ok);
        release_req(1);
        nvec++;
        if (!ok || (c1 - c0) != 3) begin
            nerr++;
            $display("FAIL tie_r1_accept: got ok=%0d gap=%0d want ok=1 gap=3", ok, c1 - c0);
        end
        sb_drain("tie");
    endtask

    task automatic test_contention();
        int acc_c[$]; int acc_id[$]; int sb;
        sb = stb_q.size();
        drv(0, 1'b1, 1'b0, 16'd5, '0);
        drv(1, 1'b1, 1'b0, 16'd7, '0);
        #1;
        for (int k = 0; k < 16 && acc_c.size() < 4; k++) begin
            if (r0_req_ready && r1_req_ready) begin
                nvec++; nerr++;
                $display("FAIL cont_both_ready: got 11 want one-hot at cyc %0d", cyc);
            end
            if (r0_req_ready || r1_req_ready) begin
                acc_c.push_back(cyc);
                acc_id.push_back(r1_req_ready ? 1 : 0);
                exp_q.push_back('{id: (r1_req_ready ? 1 : 0),
                                  d: ref_mem[r1_req_ready ? 7 : 5], c: cyc + 2});
            end
            tick();
        end
        drv(0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, '0, '0);
        sb_drain("cont");
        nvec++;
        if (acc_c.size() != 4) begin
            nerr++;
            $display("FAIL cont_count: got %0d want 4", acc_c.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nvec++;
                if (acc_id[i] != (i % 2) || acc_c[i] - acc_c[0] != 3 * i) begin
                    nerr++;
                    $display("FAIL cont_accept%0d: got id=%0d off=%0d want id=%0d off=%0d",
                             i, acc_id[i], acc_c[i] - acc_c[0], i % 2, 3 * i);
                end
            end
            nvec++;
            if (stb_q.size() - sb != 4) begin
                nerr++;
                $display("FAIL cont_strobes: got %0d want 4", stb_q.size() - sb);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    nvec++;
                    if (stb_q[sb + i].c - acc_c[0] != 3 * i + 1) begin
                        nerr++;
                        $display("FAIL cont_strobe%0d: got off=%0d want off=%0d",
                                 i, stb_q[sb + i].c - acc_c[0], 3 * i + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c; bit ok;
        issue(0, 1'b1, 16'd7, 16'h2222, 1, c, ok);
        release_req(0);
        sb_drain("rmid_pre");
        issue(0, 1'b1, 16'd7, 16'h1111, 0, c, ok);
        release_req(0);
        nvec++;
        if (!ok || mem_memo_write !== 1'b1) begin
            nerr++;
            $display("FAIL rmid_access: got ok=%0d we=%b want ok=1 we=1", ok, mem_memo_write);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (mem_memo_write !== 1'b0 || mem_memo_read !== 1'b0) begin
            nerr++;
            $display("FAIL rmid_gate: got we=%b re=%b want 0 0", mem_memo_write, mem_memo_read);
        end
        tick();
        reset = 1'b0;
        issue(1, 1'b0, 16'd7, '0, 1, c, ok);
        release_req(1);
        sb_drain("rmid");
    endtask

    task automatic test_back_to_back();
        int acc_c[$]; int sb;
        sb = stb_q.size();
        drv(1, 1'b1, 1'b0, 16'd5, '0);
        #1;
        for (int k = 0; k < 16 && acc_c.size() < 3; k++) begin
            nvec++;
            if (r0_req_ready !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_r0_ready: got %b want 0 at cyc %0d", r0_req_ready, cyc);
            end
            if (r1_req_ready) begin
                acc_c.push_back(cyc);
                exp_q.push_back('{id: 1, d: ref_mem[5], c: cyc + 2});
            end
            tick();
        end
        drv(1, 1'b0, 1'b0, '0, '0);
        sb_drain("b2b");
        nvec++;
        if (acc_c.size() != 3 || acc_c[1] - acc_c[0] != 3 || acc_c[2] - acc_c[1] != 3) begin
            nerr++;
            $display("FAIL b2b_spacing: got %0d accepts want 3 spaced by 3", acc_c.size());
        end
        for (int i = sb; i < stb_q.size(); i++) begin
            nvec++;
            if (stb_q[i].we !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_write: got we=1 want 0 at cyc %0d", stb_q[i].c);
            end
        end
    endtask

    task automatic test_input_change();
        int c; bit ok; int sb;
        sb = stb_q.size();
        issue(0, 1'b1, 16'd9, 16'h5A5A, 1, c, ok);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b1, 16'd10, 16'hFFFF);
        @(negedge clk); #1;
        nvec++;
        if (!ok || stb_q.size() - sb != 1) begin
            nerr++;
            $display("FAIL chg_strobe: got ok=%0d n=%0d want ok=1 n=1", ok, stb_q.size() - sb);
        end else if (stb_q[sb].a !== 16'd9 || stb_q[sb].d !== 16'h5A5A || stb_q[sb].we !== 1'b1) begin
            nerr++;
            $display("FAIL chg_latched: got a=%h d=%h we=%b want a=0009 d=5a5a we=1",
                     stb_q[sb].a, stb_q[sb].d, stb_q[sb].we);
        end
        drv(0, 1'b0, 1'b0, '0, '0);
        issue(1, 1'b0, 16'd9, '0, 1, c, ok);
        release_req(1);
        issue(0, 1'b0, 16'd10, '0, 1, c, ok);
        release_req(0);
        sb_drain("chg");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_input_change();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
